// File: rtl/data_mem_if.sv
// Request/response bus between a load/store requester and data_mem_ctrl.
interface data_mem_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, req_we, req_size, req_signed, addr, wdata,
    input  busy, ready, rdata, err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, addr, wdata,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressed data memory with fixed access latency and a
// one-cycle response strobe; misaligned or out-of-range accesses report err.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int INIT_WORDS  = 10
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;

  logic [3:0]  cnt;
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_signed;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0)   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access decode works from the captured request only, never the live bus.
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          out_rng, bad_align, acc_err;
  logic [31:0]   cur, ld_data, st_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign widx    = a_addr[AW+1:2];
  assign lane    = a_addr[1:0];
  assign out_rng = |a_addr[31:AW+2];
  assign cur     = mem[widx];
  assign acc_err = bad_align | out_rng;

  always_comb begin
    bad_align = 1'b0;
    case (a_size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = a_addr[0];
      2'b10:   bad_align = |a_addr[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = cur[31:24];
    case (lane)
      2'd0:    byte_sel = cur[31:24];
      2'd1:    byte_sel = cur[23:16];
      2'd2:    byte_sel = cur[15:8];
      default: byte_sel = cur[7:0];
    endcase
    half_sel = a_addr[1] ? cur[15:0] : cur[31:16];
    case (a_size)
      2'b00:   ld_data = {{24{a_signed & byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = {{16{a_signed & half_sel[15]}}, half_sel};
      default: ld_data = cur;
    endcase
  end

  // Merge store data into the current word so untouched lanes keep their bytes.
  always_comb begin
    st_word = cur;
    case (a_size)
      2'b00: begin
        case (lane)
          2'd0:    st_word[31:24] = a_wdata[7:0];
          2'd1:    st_word[23:16] = a_wdata[7:0];
          2'd2:    st_word[15:8]  = a_wdata[7:0];
          default: st_word[7:0]   = a_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (a_addr[1]) st_word[15:0]  = a_wdata[15:0];
        else           st_word[31:16] = a_wdata[15:0];
      end
      default: st_word = a_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      a_we     <= 1'b0;
      a_size   <= '0;
      a_signed <= 1'b0;
      a_addr   <= '0;
      a_wdata  <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= (i < INIT_WORDS) ? 32'(i) : 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          a_we     <= bus.req_we;
          a_size   <= bus.req_size;
          a_signed <= bus.req_signed;
          a_addr   <= bus.addr;
          a_wdata  <= bus.wdata;
          cnt      <= 4'(LATENCY);
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || a_we) ? 32'd0 : ld_data;
            if (a_we && !acc_err) mem[widx] <= st_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.ready = (state == RESP);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: stimulus queues expected responses, monitors pop and compare
// on every ready strobe. dut0 runs LATENCY=2, dut1 runs LATENCY=0.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  data_mem_if bus0();
  data_mem_if bus1();

  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(2), .INIT_WORDS(10)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0));
  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(0), .INIT_WORDS(10)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0, n_cmp = 0, n_fail = 0, nid = 0;
  logic rst0_q, rst1_q;

  always @(posedge clk) begin
    cyc++;
    rst0_q = rst0;
    rst1_q = rst1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // dut0 monitor: response contents, arrival cycle, and hold between responses.
  logic [31:0] last0 = '0;
  logic        lerr0 = 1'b0;
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst0_q === 1'b1) begin last0 = '0; lerr0 = 1'b0; end
    if (bus0.ready === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut0 unexpected ready: got rdata 0x%08h want no response (cycle %0d)", bus0.rdata, cyc);
      end else begin
        e = q0.pop_front();
        chk($sformatf("dut0 req%0d rdata", e.id), bus0.rdata, e.rdata);
        chk($sformatf("dut0 req%0d err", e.id), 32'(bus0.err), 32'(e.err));
        chk($sformatf("dut0 req%0d cycle", e.id), 32'(cyc), 32'(e.due));
        last0 = e.rdata;
        lerr0 = e.err;
      end
    end else if (rst0_q === 1'b0) begin
      chk("dut0 rdata hold", bus0.rdata, last0);
      chk("dut0 err hold", 32'(bus0.err), 32'(lerr0));
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut1 unexpected ready: got rdata 0x%08h want no response (cycle %0d)", bus1.rdata, cyc);
      end else begin
        e = q1.pop_front();
        chk($sformatf("dut1 req%0d rdata", e.id), bus1.rdata, e.rdata);
        chk($sformatf("dut1 req%0d err", e.id), 32'(bus1.err), 32'(e.err));
        chk($sformatf("dut1 req%0d cycle", e.id), 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issue one request on dut0 from a negedge; returns at the negedge after acceptance.
  // Ready is expected LATENCY+1 posedges after the accepting one (acceptance edge
  // counted as the first of LATENCY+2).
  task automatic req0(string nm, logic we, logic [1:0] sz, logic sg, logic [31:0] a,
                      logic [31:0] wd, logic [31:0] er, logic ee, bit push = 1'b1);
    int t = 0;
    while (bus0.busy !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL %s idle timeout: got busy=%b want 0", nm, bus0.busy);
      return;
    end
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_size   = sz;
    bus0.req_signed = sg;
    bus0.addr       = a;
    bus0.wdata      = wd;
    if (push) begin
      q0.push_back('{er, ee, cyc + 1 + 2 + 1, nid});
      nid++;
    end
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.addr      = 32'hFFFF_FFFF;
    bus0.wdata     = 32'h5A5A_5A5A;
    bus0.req_size  = 2'b11;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb, a, t;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'b10;
    bus0.req_signed = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b10;
    bus1.req_signed = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset busy",  32'(bus0.busy),  32'd0);
    chk("reset ready", 32'(bus0.ready), 32'd0);
    chk("reset rdata", bus0.rdata,      32'd0);
    chk("reset err",   32'(bus0.err),   32'd0);

    req0("lw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0004, 1'b0);
    nb = 0;
    while (bus0.busy === 1'b1 && nb < 20) begin nb++; @(negedge clk); end
    chk("busy cycles lw 0x10", 32'(nb), 32'd4);

    req0("sw 0x20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h8000_FF7F, 32'h0, 1'b0);
    req0("lb 0x20",  1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0);
    req0("lbu 0x22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h0000_00FF, 1'b0);
    req0("lh 0x22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_FF7F, 1'b0);
    req0("lhu 0x20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h0000_8000, 1'b0);
    req0("sb 0x21",  1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AA, 32'h0, 1'b0);
    req0("sh 0x26",  1'b1, 2'b01, 1'b0, 32'h26, 32'hABCD_5555, 32'h0, 1'b0);
    req0("lw 0x20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80AA_FF7F, 1'b0);
    req0("lw 0x24",  1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0000_5555, 1'b0);
    req0("lw s 0x20", 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h80AA_FF7F, 1'b0);
    // Error cases: misalignment, reserved size, range and high address bits.
    req0("lw 0x22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
    req0("sw 0x100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1);
    req0("lw 0x00",  1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    req0("lh 0x21",  1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
    req0("size11",   1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
    req0("lw hi",    1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    req0("lw 0xfc",  1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b0);
    req0("sw 0xfc",  1'b1, 2'b10, 1'b0, 32'hFC, 32'h1122_3344, 32'h0, 1'b0);
    req0("lbu 0xff", 1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, 32'h0000_0044, 1'b0);
    req0("lb 0xfc",  1'b0, 2'b00, 1'b1, 32'hFC, 32'h0, 32'h0000_0011, 1'b0);

    // Abort a store mid-access: no response, memory back to preload values.
    req0("sw abort", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("abort busy",  32'(bus0.busy),  32'd0);
    chk("abort ready", 32'(bus0.ready), 32'd0);
    repeat (6) @(negedge clk);
    req0("lw 0x08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0000_0002, 1'b0);
    req0("lw 0x20 post", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_0008, 1'b0);

    // LATENCY=0 with req_valid held: one response every 3 cycles; the address
    // change made while busy must only affect the next acceptance.
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_size = 2'b10;
    bus1.req_signed = 1'b0; bus1.addr = 32'h10;
    a = cyc + 1;
    q1.push_back('{32'h4, 1'b0, a + 1, 100});
    q1.push_back('{32'h5, 1'b0, a + 4, 101});
    q1.push_back('{32'h5, 1'b0, a + 7, 102});
    @(negedge clk);
    bus1.addr = 32'h14;
    repeat (8) @(negedge clk);
    bus1.req_valid = 1'b0;

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin @(negedge clk); t++; end
    chk("dut0 pending responses", 32'(q0.size()), 32'd0);
    chk("dut1 pending responses", 32'(q1.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
